weight_sweep_ctrl: RTL and testbench
====================================

// Module: weight_sweep_ctrl
// PURPOSE
// Sequencer for the weight BRAM (weights_ram, one CLASSES x 8-bit word per pixel address).
// Runs one full sweep over all IMG_SIZE addresses in one of two modes:
//   - INFER: read-only; streams each word to the classifier.
//   - TRAIN: read-modify-write; for each address, waits for the delta source and fires en_update.
// Sole owner of bram_addr / en_update.
// PARAMETERS
// IMG_SIZE  256                  number of pixel addresses swept (0 .. IMG_SIZE-1)
// ADDR_W    $clog2(IMG_SIZE)=8   width of bram_addr / wt_addr
// RD_LAT    1                    BRAM read latency in cycles (addr change -> douta valid), >=1
// PORTS
// clk          in   1       system clock, all state on rising edge
// rst          in   1       reset, asynchronous, active-high
// start_infer  in   1       pulse: begin INFER sweep (sampled only in IDLE)
// start_train  in   1       pulse: begin TRAIN sweep (sampled only in IDLE)
// abort        in   1       synchronous: terminate current sweep, no done pulse
// busy         out  1       high from the cycle after an accepted start until return to IDLE
// done         out  1       one-cycle pulse after the last address of a sweep completes
// bram_addr    out  ADDR_W  registered address to weights_ram
// en_update    out  1       write enable to weights_ram (combinational, see TRAIN)
// wt_valid     out  1       INFER: weights_ram output valid for wt_addr, one-cycle pulse
// wt_addr      out  ADDR_W  address belonging to current wt_valid
// wt_last      out  1       qualifies wt_valid for address IMG_SIZE-1
// delta_ready  out  1       TRAIN: controller waiting for weight_deltas of bram_addr
// delta_valid  in   1       TRAIN: weight_deltas for bram_addr present and stable
// BEHAVIOUR
// Reset values:
//   - state=IDLE, bram_addr=0, lat_cnt=0.
//   - All outputs 0: busy, done, wt_valid, wt_last, delta_ready, en_update.
// States: IDLE, RD_WAIT, INF_OUT, TR_WAIT, DONE.
// IDLE:
//   - start_train -> RD_WAIT, mode=TRAIN.
//   - Else start_infer -> RD_WAIT, mode=INFER.
//   - Both high in the same cycle: TRAIN wins, infer request dropped.
//   - Starts outside IDLE ignored (not queued).
// RD_WAIT:
//   - bram_addr held; lat_cnt counts 0..RD_LAT-1.
//   - On the RD_LAT-th cycle go to INF_OUT (INFER) or TR_WAIT (TRAIN).
// INF_OUT (1 cycle):
//   - wt_valid=1, wt_addr=bram_addr, wt_last=(bram_addr==IMG_SIZE-1).
//   - Next: bram_addr+1 -> RD_WAIT, or -> DONE after the last address.
//   - Throughput: one word per RD_LAT+1 cycles, no backpressure.
// TR_WAIT:
//   - delta_ready=1, bram_addr held, douta valid.
//   - en_update = delta_ready & delta_valid & ~abort (combinational, same cycle).
//   - The write commits at that clock edge using the current douta.
//   - Then: bram_addr+1 -> RD_WAIT, or -> DONE after the last address.
//   - Stays in TR_WAIT indefinitely while delta_valid=0.
// DONE (1 cycle): done=1, busy=0 next cycle, bram_addr returns to 0, -> IDLE.
// Exactly one en_update per address per TRAIN sweep: IMG_SIZE writes total, never two at one address.
// Address counter never wraps mid-sweep; increment from IMG_SIZE-1 is suppressed (goes to DONE).
// abort in any non-IDLE state:
//   - Next state IDLE, bram_addr=0, no done.
//   - en_update forced 0 in the abort cycle.
//   - Writes already committed stay.
// Async rst mid-sweep:
//   - All outputs drop immediately (en_update is gated by state regs).
//   - Partial TRAIN writes are not rolled back.
// Sweep cycle counts:
//   - INFER: IMG_SIZE*(RD_LAT+1)+1 cycles from busy rise to done (incl. DONE state).
//   - TRAIN: same when delta_valid is tied high.
// STRUCTURE
// Shared package fpgann_pkg:
//   - typedef enum logic [2:0] sweep_state_t {IDLE,RD_WAIT,INF_OUT,TR_WAIT,DONE}.
//   - typedef enum logic sweep_mode_t {MODE_INFER,MODE_TRAIN}.
//   - localparams IMG_SIZE_DEF=256, CLASSES_DEF=10, LEARNING_RATE=8'h04.
// Single module; latency counter and address counter inline; no sub-module.
// TESTING
// Bench instantiates weights_ram (behavioural BRAM model, RD_LAT=1) + weight_sweep_ctrl; preload word[a]=a per class.
// T1 start_infer pulse -> 256 wt_valid pulses, every 2 cycles, wt_addr 0..255, weights[k]==addr; wt_last only at 255; done at cycle 513; en_update never 1.
// T2 start_train, delta_valid tied 1, deltas all 8'h08 -> each word +1 ((4*8)>>5), exactly 256 en_update; second INFER sweep reads a+1.
// T3 start_train, delta_valid stalled 10 cycles at addr 7 -> bram_addr stays 7, delta_ready stays 1, en_update 0 until valid, then single write.
// T4 start_infer and start_train same cycle -> TRAIN sweep; start_infer pulsed mid-sweep ignored; busy high until done.
// T5 abort at addr 100 (TRAIN) -> en_update 0 that cycle, IDLE next cycle, no done; words 0..99 updated, 100..255 unchanged.
// T6 rst asserted asynchronously mid-TR_WAIT -> en_update, busy, delta_ready low before next edge; bram_addr=0; new start works.

Source files
------------

// File: rtl/fpgann_pkg.sv
`default_nettype none
// ============================================================================
// fpgann_pkg
// Shared types and constants for the weight sweep sequencer and its users.
// Revision: 1.0
// ============================================================================
package fpgann_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_WAIT = 3'd1,
      INF_OUT = 3'd2,
      TR_WAIT = 3'd3,
      DONE    = 3'd4
   } sweep_state_t;

   typedef enum logic {
      MODE_INFER = 1'b0,
      MODE_TRAIN = 1'b1
   } sweep_mode_t;

   localparam int         IMG_SIZE_DEF  = 256;
   localparam int         CLASSES_DEF   = 10;
   localparam logic [7:0] LEARNING_RATE = 8'h04;

endpackage
`default_nettype wire

// File: rtl/weight_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// weight_sweep_ctrl
// Sweeps every weights_ram address once, either streaming words (INFER) or
// read-modify-writing them against an external delta source (TRAIN).
// Revision: 1.0
// ============================================================================
module weight_sweep_ctrl
   import fpgann_pkg::*;
#(
   parameter int IMG_SIZE = IMG_SIZE_DEF,
   parameter int ADDR_W   = $clog2(IMG_SIZE),
   parameter int RD_LAT   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_infer,
   input  logic              start_train,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              en_update,
   output logic              wt_valid,
   output logic [ADDR_W-1:0] wt_addr,
   output logic              wt_last,
   output logic              delta_ready,
   input  logic              delta_valid
);

   localparam int                 c_LAT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [c_LAT_W-1:0] c_LAT_LAST  = c_LAT_W'(RD_LAT - 1);
   localparam logic [ADDR_W-1:0]  c_LAST_ADDR = ADDR_W'(IMG_SIZE - 1);

   sweep_state_t        r_state, w_state_nxt;
   sweep_mode_t         r_mode, w_mode_nxt;
   logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
   logic [c_LAT_W-1:0]  r_lat_cnt, w_lat_nxt;
   logic                w_step;

   // An address is finished when its word was presented (INFER) or its delta accepted (TRAIN).
   assign w_step = (r_state == INF_OUT) || ((r_state == TR_WAIT) && delta_valid);

   always_comb begin
      w_state_nxt = r_state;
      w_mode_nxt  = r_mode;
      w_addr_nxt  = r_addr;
      w_lat_nxt   = r_lat_cnt;
      if ((r_state != IDLE) && abort) begin
         w_state_nxt = IDLE;
         w_addr_nxt  = '0;
         w_lat_nxt   = '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_train) begin
                  w_state_nxt = RD_WAIT;
                  w_mode_nxt  = MODE_TRAIN;
               end else if (start_infer) begin
                  w_state_nxt = RD_WAIT;
                  w_mode_nxt  = MODE_INFER;
               end
            end
            RD_WAIT: begin
               if (r_lat_cnt == c_LAT_LAST) begin
                  w_lat_nxt   = '0;
                  w_state_nxt = (r_mode == MODE_TRAIN) ? TR_WAIT : INF_OUT;
               end else begin
                  w_lat_nxt = r_lat_cnt + 1'b1;
               end
            end
            INF_OUT, TR_WAIT: begin
               if (w_step) begin
                  if (r_addr == c_LAST_ADDR) begin
                     w_state_nxt = DONE;
                  end else begin
                     w_state_nxt = RD_WAIT;
                     w_addr_nxt  = r_addr + 1'b1;
                  end
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_addr_nxt  = '0;
               w_lat_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_mode    <= MODE_INFER;
         r_addr    <= '0;
         r_lat_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_mode    <= w_mode_nxt;
         r_addr    <= w_addr_nxt;
         r_lat_cnt <= w_lat_nxt;
      end
   end

   // Every output decodes the state register, so an async reset drops them at once.
   assign busy        = (r_state != IDLE);
   assign done        = (r_state == DONE);
   assign bram_addr   = r_addr;
   assign wt_valid    = (r_state == INF_OUT);
   assign wt_addr     = r_addr;
   assign wt_last     = wt_valid && (r_addr == c_LAST_ADDR);
   assign delta_ready = (r_state == TR_WAIT);
   assign en_update   = delta_ready & delta_valid & ~abort;

endmodule
`default_nettype wire

// File: tb/tb_weight_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// tb_weight_sweep_ctrl
// Directed bench: weight_sweep_ctrl driving a behavioural weights_ram model.
// Revision: 1.0
// ============================================================================
module tb_weight_sweep_ctrl;
   import fpgann_pkg::*;

   localparam int         c_IMG   = 256;
   localparam int         c_CLS   = CLASSES_DEF;
   localparam logic [7:0] c_DELTA = 8'h08;
   localparam int         c_LIMIT = 3000;

   logic clk = 1'b0;
   logic rst, start_infer, start_train, abort, delta_valid, load;
   logic busy, done, en_update, wt_valid, wt_last, delta_ready;
   logic [7:0] bram_addr, wt_addr;
   logic [c_CLS*8-1:0] mem [c_IMG];
   logic [c_CLS*8-1:0] douta;
   int   ref_val [c_IMG];
   bit   written [c_IMG];
   int   total = 0, bad = 0;
   int   n_valid, n_en, n_done, done_cyc, seq_err, data_err, last_cnt, dup;
   int   stall_seen, stall_err, abort_err, cyc;

   always #5 clk = ~clk;

   weight_sweep_ctrl #(.IMG_SIZE(c_IMG), .ADDR_W(8), .RD_LAT(1)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .start_infer (start_infer),
      .start_train (start_train),
      .abort       (abort),
      .busy        (busy),
      .done        (done),
      .bram_addr   (bram_addr),
      .en_update   (en_update),
      .wt_valid    (wt_valid),
      .wt_addr     (wt_addr),
      .wt_last     (wt_last),
      .delta_ready (delta_ready),
      .delta_valid (delta_valid)
   );

   // Each class byte grows by (LEARNING_RATE*delta)>>5, i.e. +1 for delta 8'h08.
   function automatic logic [c_CLS*8-1:0] upd(input logic [c_CLS*8-1:0] w);
      logic [c_CLS*8-1:0] r;
      logic [15:0]        inc;
      inc = (16'(LEARNING_RATE) * 16'(c_DELTA)) >> 5;
      for (int k = 0; k < c_CLS; k++) r[8*k +: 8] = w[8*k +: 8] + inc[7:0];
      return r;
   endfunction

   always @(posedge clk) begin
      if (load) begin
         for (int a = 0; a < c_IMG; a++) mem[a] <= {c_CLS{8'(a)}};
      end else begin
         douta <= mem[bram_addr];
         if (en_update) mem[bram_addr] <= upd(douta);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Runs one sweep from the current negedge; -1 disables stall/abort/mid-start.
   task automatic sweep(input logic si, input logic st, input int stall_a, input int stall_n,
                        input int abort_a, input int mid_cyc);
      int   stall_left;
      int   exp_a;
      int   it;
      logic stalling, aborting;
      stall_left = stall_n; exp_a = 0; it = 0;
      n_valid = 0; n_en = 0; n_done = 0; done_cyc = 0; seq_err = 0; data_err = 0;
      last_cnt = 0; dup = 0; stall_seen = 0; stall_err = 0; abort_err = 0; cyc = 0;
      for (int i = 0; i < c_IMG; i++) written[i] = 1'b0;
      start_infer = si;
      start_train = st;
      while (1) begin
         @(negedge clk);
         start_infer = (cyc == mid_cyc);
         start_train = 1'b0;
         delta_valid = 1'b1;
         abort       = 1'b0;
         stalling    = 1'b0;
         aborting    = 1'b0;
         if (stall_a >= 0 && delta_ready && int'(bram_addr) == stall_a && stall_left > 0) begin
            delta_valid = 1'b0;
            stalling    = 1'b1;
            stall_left--;
            stall_seen++;
         end
         if (abort_a >= 0 && delta_ready && int'(bram_addr) == abort_a) begin
            abort    = 1'b1;
            aborting = 1'b1;
         end
         #1;
         it++;
         if (busy) cyc++;
         if (aborting && en_update) abort_err++;
         if (stalling && en_update) stall_err++;
         if (wt_valid) begin
            n_valid++;
            if (int'(wt_addr) != exp_a || cyc != 2*exp_a + 2) seq_err++;
            for (int k = 0; k < c_CLS; k++)
               if (douta[8*k +: 8] != 8'(ref_val[wt_addr])) data_err++;
            if (wt_last) begin
               last_cnt++;
               if (wt_addr != 8'hFF) seq_err++;
            end
            exp_a++;
         end
         if (en_update) begin
            n_en++;
            if (written[bram_addr]) dup++;
            written[bram_addr] = 1'b1;
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
         end
         if ((!busy && cyc > 0) || it >= c_LIMIT) break;
      end
      start_infer = 1'b0;
      abort       = 1'b0;
      delta_valid = 1'b1;
      chk("sweep_timeout", 32'(it >= c_LIMIT), 0);
   endtask

   task automatic check_infer(input string pfx);
      sweep(1'b1, 1'b0, -1, 0, -1, -1);
      chk({pfx, "_valid_cnt"}, n_valid, 256);
      chk({pfx, "_seq_err"}, seq_err, 0);
      chk({pfx, "_data_err"}, data_err, 0);
      chk({pfx, "_last_cnt"}, last_cnt, 1);
      chk({pfx, "_done_cyc"}, done_cyc, 513);
      chk({pfx, "_en_cnt"}, n_en, 0);
   endtask

   initial begin
      int it;
      rst = 1'b1; load = 1'b1;
      start_infer = 1'b0; start_train = 1'b0; abort = 1'b0; delta_valid = 1'b1;
      for (int a = 0; a < c_IMG; a++) ref_val[a] = a;
      repeat (2) @(negedge clk);
      load = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_wt_valid", wt_valid, 0);
      chk("rst_wt_last", wt_last, 0);
      chk("rst_delta_ready", delta_ready, 0);
      chk("rst_en_update", en_update, 0);
      chk("rst_bram_addr", bram_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;

      // T1: plain inference sweep over the preloaded image
      check_infer("t1");

      // T2: training with deltas always present, then read the result back
      sweep(1'b0, 1'b1, -1, 0, -1, -1);
      chk("t2_en_cnt", n_en, 256);
      chk("t2_dup", dup, 0);
      chk("t2_done_cnt", n_done, 1);
      chk("t2_done_cyc", done_cyc, 513);
      chk("t2_valid_cnt", n_valid, 0);
      for (int a = 0; a < c_IMG; a++) ref_val[a] += 1;
      check_infer("t2");

      // T3: delta source stalls 10 cycles at address 7
      sweep(1'b0, 1'b1, 7, 10, -1, -1);
      chk("t3_stall_seen", stall_seen, 10);
      chk("t3_stall_en", stall_err, 0);
      chk("t3_en_cnt", n_en, 256);
      chk("t3_dup", dup, 0);
      chk("t3_done_cyc", done_cyc, 523);
      for (int a = 0; a < c_IMG; a++) ref_val[a] += 1;

      // T4: simultaneous starts pick TRAIN; a mid-sweep infer start is dropped
      sweep(1'b1, 1'b1, -1, 0, -1, 50);
      chk("t4_en_cnt", n_en, 256);
      chk("t4_valid_cnt", n_valid, 0);
      chk("t4_done_cnt", n_done, 1);
      chk("t4_done_cyc", done_cyc, 513);
      @(negedge clk);
      #1;
      chk("t4_no_queue", busy, 0);
      for (int a = 0; a < c_IMG; a++) ref_val[a] += 1;

      // T5: abort while waiting for the delta of address 100
      sweep(1'b0, 1'b1, -1, 0, 100, -1);
      chk("t5_en_cnt", n_en, 100);
      chk("t5_abort_en", abort_err, 0);
      chk("t5_done_cnt", n_done, 0);
      chk("t5_cyc", cyc, 202);
      chk("t5_addr", bram_addr, 0);
      for (int a = 0; a < 100; a++) ref_val[a] += 1;
      check_infer("t5");

      // T6: asynchronous reset in TR_WAIT of address 20
      start_train = 1'b1;
      @(negedge clk);
      start_train = 1'b0;
      delta_valid = 1'b1;
      it = 0;
      while (!(busy && !delta_ready && bram_addr == 8'd20) && it < c_LIMIT) begin
         @(negedge clk);
         it++;
      end
      chk("t6_timeout", 32'(it >= c_LIMIT), 0);
      delta_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("t6_ready", delta_ready, 1);
      chk("t6_hold_en", en_update, 0);
      delta_valid = 1'b1;
      #1;
      chk("t6_en", en_update, 1);
      #1;
      rst = 1'b1;
      #1;
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_ready", delta_ready, 0);
      chk("t6_rst_en", en_update, 0);
      chk("t6_rst_addr", bram_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      for (int a = 0; a < 20; a++) ref_val[a] += 1;
      check_infer("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
